// File: rtl/pal_sync_gen_if.sv
// Video timing bundle produced by pal_sync_gen: counters, blanking flags,
// composite sync level and field bookkeeping.
interface pal_sync_gen_if;
  logic [8:0] cntHS;
  logic [8:0] cntVS;
  logic       hsync;
  logic       vbl;
  logic       out_sync;
  logic       field_tick;
  logic [7:0] frame_cnt;

  modport master (
    output cntHS,
    output cntVS,
    output hsync,
    output vbl,
    output out_sync,
    output field_tick,
    output frame_cnt
  );

  modport slave (
    input cntHS,
    input cntVS,
    input hsync,
    input vbl,
    input out_sync,
    input field_tick,
    input frame_cnt
  );
endinterface

// File: rtl/pal_sync_gen.sv
// PAL composite timing generator: pixel/line counters, blanking decodes and sync.
// Macro SYNC_SERRATION_EN selects serrated broad/equalizing pulses; undefined gives simplified sync.
module pal_sync_gen #(
  parameter int H_TOTAL        = 512,
  parameter int H_SYNC         = 38,
  parameter int H_EQ           = 19,
  parameter int H_BLANK_END    = 96,
  parameter int V_TOTAL        = 312,
  parameter int V_ACTIVE_START = 40,
  parameter int V_ACTIVE_END   = 296
) (
  input  logic           pixel_clk,
  input  logic           rst,
  pal_sync_gen_if.master vid
);

  localparam logic [8:0] H_LAST       = 9'(H_TOTAL - 1);
  localparam logic [8:0] H_HALF       = 9'(H_TOTAL / 2);
  localparam logic [8:0] H_SYNC_W     = 9'(H_SYNC);
  localparam logic [8:0] H_BLANK_W    = 9'(H_BLANK_END);
  localparam logic [8:0] H_EQ_W       = 9'(H_EQ);
  localparam logic [8:0] H_EQ2_END    = 9'(H_TOTAL / 2 + H_EQ);
  localparam logic [8:0] H_BROAD1_END = 9'(H_TOTAL / 2 - H_SYNC);
  localparam logic [8:0] H_BROAD2_END = 9'(H_TOTAL - H_SYNC);
  localparam logic [8:0] V_LAST       = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_PRELAST    = 9'(V_TOTAL - 2);
  localparam logic [8:0] V_ACT_START  = 9'(V_ACTIVE_START);
  localparam logic [8:0] V_ACT_END    = 9'(V_ACTIVE_END);

  typedef enum logic [1:0] {
    LINE_NORMAL,
    LINE_EQ,
    LINE_BROAD
  } line_class_t;

  logic [8:0]  cnt_h;
  logic [8:0]  cnt_v;
  logic [7:0]  frame_cnt;
  logic        out_sync;
  logic        field_tick;
  line_class_t line_class;
  logic        sync_low;

  always_comb begin
    line_class = LINE_NORMAL;
    if (cnt_v <= 9'd2) begin
      line_class = LINE_BROAD;
    end else if (cnt_v == 9'd3 || cnt_v == 9'd4 ||
                 cnt_v == V_PRELAST || cnt_v == V_LAST) begin
      line_class = LINE_EQ;
    end
  end

  // Sync tip decode for the current counter position; registered below.
  always_comb begin
    sync_low = 1'b0;
`ifdef SYNC_SERRATION_EN
    case (line_class)
      LINE_BROAD:
        sync_low = (cnt_h < H_BROAD1_END) ||
                   (cnt_h >= H_HALF && cnt_h < H_BROAD2_END);
      LINE_EQ:
        sync_low = (cnt_h < H_EQ_W) ||
                   (cnt_h >= H_HALF && cnt_h < H_EQ2_END);
      default:
        sync_low = (cnt_h < H_SYNC_W);
    endcase
`else
    case (line_class)
      LINE_BROAD: sync_low = 1'b1;
      default:    sync_low = (cnt_h < H_SYNC_W);
    endcase
`endif
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst) begin
      cnt_h      <= '0;
      cnt_v      <= '0;
      frame_cnt  <= '0;
      out_sync   <= 1'b1;
      field_tick <= 1'b0;
    end else begin
      if (cnt_h == H_LAST) begin
        cnt_h <= '0;
        if (cnt_v == V_LAST) begin
          cnt_v     <= '0;
          frame_cnt <= frame_cnt + 8'd1;
        end else begin
          cnt_v <= cnt_v + 9'd1;
        end
      end else begin
        cnt_h <= cnt_h + 9'd1;
      end
      // Both lag the counters by one clock so they stay mutually aligned.
      out_sync   <= ~sync_low;
      field_tick <= (cnt_h == 9'd0) && (cnt_v == 9'd0);
    end
  end

  assign vid.cntHS      = cnt_h;
  assign vid.cntVS      = cnt_v;
  assign vid.frame_cnt  = frame_cnt;
  assign vid.out_sync   = out_sync;
  assign vid.field_tick = field_tick;
  assign vid.hsync      = (cnt_h < H_BLANK_W);
  assign vid.vbl        = (cnt_v < V_ACT_START) || (cnt_v >= V_ACT_END);

endmodule

// File: tb/tb_pal_sync_gen.sv
// Bench for pal_sync_gen: a main instance with default horizontal timing and a
// shortened field, plus a tiny instance used to reach the frame counter wrap.
module tb_pal_sync_gen;

  localparam int MV = 32;   // main instance lines per field (equalizing: 3,4,30,31)

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pal_sync_gen_if vid();
  pal_sync_gen_if vsm();

  pal_sync_gen #(
    .H_TOTAL(512), .H_SYNC(38), .H_EQ(19), .H_BLANK_END(96),
    .V_TOTAL(MV), .V_ACTIVE_START(8), .V_ACTIVE_END(28)
  ) dut (
    .pixel_clk(clk),
    .rst(rst),
    .vid(vid)
  );

  pal_sync_gen #(
    .H_TOTAL(8), .H_SYNC(3), .H_EQ(1), .H_BLANK_END(4),
    .V_TOTAL(8), .V_ACTIVE_START(5), .V_ACTIVE_END(6)
  ) dut_small (
    .pixel_clk(clk),
    .rst(rst),
    .vid(vsm)
  );

  int total = 0;
  int bad   = 0;

  // Reference position of the main instance, advanced once per clock.
  int m_h  = 0;
  int m_v  = 0;
  int m_fc = 0;
  bit sb_en = 1'b0;
  logic [1:0] exp_q[$];   // {field_tick, out_sync}

  function automatic logic model_low(input int h, input int v);
    bit broad;
    bit eq;
    broad = (v <= 2);
    eq    = (v == 3) || (v == 4) || (v == MV - 2) || (v == MV - 1);
`ifdef SYNC_SERRATION_EN
    if (broad) return (h < 218) || (h >= 256 && h < 474);
    if (eq)    return (h < 19) || (h >= 256 && h < 275);
    return h < 38;
`else
    if (broad) return 1'b1;
    if (eq)    return h < 38;
    return h < 38;
`endif
  endfunction

  task automatic tick();
    if (sb_en)
      exp_q.push_back({(rst && m_h == 0 && m_v == 0), (rst ? ~model_low(m_h, m_v) : 1'b1)});
    @(negedge clk);
    if (!rst) begin
      m_h = 0; m_v = 0; m_fc = 0;
    end else if (m_h == 511) begin
      m_h = 0;
      if (m_v == MV - 1) begin
        m_v = 0;
        m_fc = (m_fc + 1) % 256;
      end else begin
        m_v++;
      end
    end else begin
      m_h++;
    end
  endtask

  task automatic advance_to(input int h, input int v);
    int n;
    n = 0;
    while (!(m_h == h && m_v == v) && n < 40000) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (700) tick();
    total++; if (vid.cntHS !== 9'(m_h) || vid.cntVS !== 9'(m_v)) begin bad++;
      $display("FAIL reset_precount: got %0d/%0d expected %0d/%0d", vid.cntHS, vid.cntVS, m_h, m_v); end
    rst = 1'b0;
    repeat (5) tick();
    total++; if (vid.cntHS !== 9'd0) begin bad++; $display("FAIL reset_cnths: got %0d expected 0", vid.cntHS); end
    total++; if (vid.cntVS !== 9'd0) begin bad++; $display("FAIL reset_cntvs: got %0d expected 0", vid.cntVS); end
    total++; if (vid.out_sync !== 1'b1) begin bad++; $display("FAIL reset_out_sync: got %b expected 1", vid.out_sync); end
    total++; if (vid.frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_frame_cnt: got %0d expected 0", vid.frame_cnt); end
    total++; if (vid.field_tick !== 1'b0) begin bad++; $display("FAIL reset_field_tick: got %b expected 0", vid.field_tick); end
    total++; if (vid.hsync !== 1'b1 || vid.vbl !== 1'b1) begin bad++;
      $display("FAIL reset_flags: got hsync=%b vbl=%b expected 1/1", vid.hsync, vid.vbl); end
    total++; if (vsm.frame_cnt !== 8'd0) begin bad++; $display("FAIL reset_small_frame: got %0d expected 0", vsm.frame_cnt); end
    rst = 1'b1;
    tick();
    total++; if (vid.cntHS !== 9'd1 || vid.cntVS !== 9'd0) begin bad++;
      $display("FAIL release_count: got %0d/%0d expected 1/0", vid.cntHS, vid.cntVS); end
    total++; if (vid.field_tick !== 1'b1 || vid.out_sync !== 1'b0) begin bad++;
      $display("FAIL release_first_field: got tick=%b sync=%b expected 1/0", vid.field_tick, vid.out_sync); end
  endtask

  task automatic test_line_shapes();
    logic bits [512];
    int   runs[$];
    int   exp1[$];
    int   exp3[$];
    int   len;
`ifdef SYNC_SERRATION_EN
    exp1 = '{218, 38, 218, 38};
    exp3 = '{19, 237, 19, 237};
`else
    exp1 = '{512};
    exp3 = '{38, 474};
`endif
    for (int line = 1; line <= 3; line += 2) begin
      advance_to(0, line);
      for (int i = 0; i < 512; i++) begin
        tick();
        bits[i] = vid.out_sync;
      end
      runs.delete();
      len = 1;
      for (int i = 1; i < 512; i++) begin
        if (bits[i] === bits[i-1]) len++;
        else begin runs.push_back(len); len = 1; end
      end
      runs.push_back(len);
      total++; if (bits[0] !== 1'b0) begin bad++;
        $display("FAIL line%0d_start_level: got %b expected 0", line, bits[0]); end
      if (line == 1) begin
        total++; if (runs.size() != exp1.size()) begin bad++;
          $display("FAIL line1_run_count: got %0d expected %0d", runs.size(), exp1.size()); end
        for (int k = 0; k < exp1.size() && k < runs.size(); k++) begin
          total++; if (runs[k] != exp1[k]) begin bad++;
            $display("FAIL line1_run%0d: got %0d expected %0d", k, runs[k], exp1[k]); end
        end
      end else begin
        total++; if (runs.size() != exp3.size()) begin bad++;
          $display("FAIL line3_run_count: got %0d expected %0d", runs.size(), exp3.size()); end
        for (int k = 0; k < exp3.size() && k < runs.size(); k++) begin
          total++; if (runs[k] != exp3[k]) begin bad++;
            $display("FAIL line3_run%0d: got %0d expected %0d", k, runs[k], exp3[k]); end
        end
      end
    end
  endtask

  task automatic test_h_wrap();
    int low_len;
    int hcnt;
    int first0;
    int pos_err;
    advance_to(511, 10);
    total++; if (vid.cntHS !== 9'd511 || vid.cntVS !== 9'd10) begin bad++;
      $display("FAIL hwrap_before: got %0d/%0d expected 511/10", vid.cntHS, vid.cntVS); end
    tick();
    total++; if (vid.cntHS !== 9'd0 || vid.cntVS !== 9'd11) begin bad++;
      $display("FAIL hwrap_after: got %0d/%0d expected 0/11", vid.cntHS, vid.cntVS); end
    total++; if (vid.out_sync !== 1'b1) begin bad++;
      $display("FAIL hwrap_sync_lag: got %b expected 1", vid.out_sync); end
    tick();
    low_len = 0;
    while (vid.out_sync === 1'b0 && low_len < 600) begin
      low_len++;
      tick();
    end
    total++; if (low_len != 38) begin bad++;
      $display("FAIL hsync_pulse_width: got %0d expected 38", low_len); end
    advance_to(0, 12);
    hcnt = 0; first0 = -1; pos_err = 0;
    for (int i = 0; i < 512; i++) begin
      if (vid.cntHS !== 9'(i)) pos_err++;
      if (vid.hsync === 1'b1) hcnt++;
      else if (first0 < 0) first0 = i;
      tick();
    end
    total++; if (hcnt != 96 || first0 != 96) begin bad++;
      $display("FAIL hblank_window: got count=%0d first_active=%0d expected 96/96", hcnt, first0); end
    total++; if (pos_err != 0) begin bad++;
      $display("FAIL line_position: got %0d bad cycles expected 0", pos_err); end
  endtask

  task automatic test_blanking();
    int active;
    int trk_err;
    int lines[4];
    logic vexp[4];
    lines = '{7, 8, 27, 28};
    vexp  = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      advance_to(200, lines[k]);
      total++; if (vid.vbl !== vexp[k]) begin bad++;
        $display("FAIL vbl_line%0d: got %b expected %b", lines[k], vid.vbl, vexp[k]); end
    end
    active = 0; trk_err = 0;
    for (int i = 0; i < 512 * MV; i++) begin
      if (vid.hsync === 1'b0 && vid.vbl === 1'b0) active++;
      if (vid.cntHS !== 9'(m_h) || vid.cntVS !== 9'(m_v) || vid.frame_cnt !== 8'(m_fc)) trk_err++;
      tick();
    end
    total++; if (active != 416 * 20) begin bad++;
      $display("FAIL active_pixels: got %0d expected %0d", active, 416 * 20); end
    total++; if (trk_err != 0) begin bad++;
      $display("FAIL counter_tracking: got %0d bad cycles expected 0", trk_err); end
  endtask

  task automatic test_sync_scoreboard();
    logic [1:0] e;
    logic [1:0] got;
    advance_to(0, MV - 4);
    sb_en = 1'b1;
    for (int i = 0; i < 9 * 512; i++) begin
      tick();
      e = exp_q.pop_front();
      got = {vid.field_tick, vid.out_sync};
      total++; if (got !== e) begin bad++;
        $display("FAIL sync_sb line %0d px %0d: got %b expected %b", m_v, m_h, got, e); end
    end
    sb_en = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++;
      $display("FAIL sb_drain: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_field_wrap();
    logic [7:0] fc0;
    int highs;
    advance_to(511, MV - 1);
    fc0 = 8'(m_fc);
    total++; if (vid.frame_cnt !== fc0) begin bad++;
      $display("FAIL fwrap_frame_before: got %0d expected %0d", vid.frame_cnt, fc0); end
    tick();
    total++; if (vid.cntHS !== 9'd0 || vid.cntVS !== 9'd0) begin bad++;
      $display("FAIL fwrap_counters: got %0d/%0d expected 0/0", vid.cntHS, vid.cntVS); end
    total++; if (vid.frame_cnt !== fc0 + 8'd1) begin bad++;
      $display("FAIL fwrap_frame_after: got %0d expected %0d", vid.frame_cnt, fc0 + 8'd1); end
    total++; if (vid.field_tick !== 1'b0) begin bad++;
      $display("FAIL fwrap_tick_early: got %b expected 0", vid.field_tick); end
    tick();
    total++; if (vid.field_tick !== 1'b1) begin bad++;
      $display("FAIL fwrap_tick: got %b expected 1", vid.field_tick); end
    highs = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (vid.field_tick === 1'b1) highs++;
    end
    total++; if (highs != 0) begin bad++;
      $display("FAIL fwrap_tick_width: got %0d extra cycles expected 0", highs); end
  endtask

  task automatic test_frame_wrap();
    int n;
    n = 0;
    while (!(vsm.frame_cnt === 8'd255 && vsm.cntVS === 9'd7 && vsm.cntHS === 9'd7) && n < 20000) begin
      tick();
      n++;
    end
    total++; if (n >= 20000) begin bad++;
      $display("FAIL frame_wrap_timeout: got %0d cycles expected < 20000", n); end
    else begin
      tick();
      total++; if (vsm.frame_cnt !== 8'd0) begin bad++;
        $display("FAIL frame_wrap_value: got %0d expected 0", vsm.frame_cnt); end
      total++; if (vsm.cntHS !== 9'd0 || vsm.cntVS !== 9'd0) begin bad++;
        $display("FAIL frame_wrap_counters: got %0d/%0d expected 0/0", vsm.cntHS, vsm.cntVS); end
      tick();
      total++; if (vsm.field_tick !== 1'b1) begin bad++;
        $display("FAIL frame_wrap_tick: got %b expected 1", vsm.field_tick); end
    end
  endtask

  initial begin
    test_reset();
    test_line_shapes();
    test_h_wrap();
    test_blanking();
    test_sync_scoreboard();
    test_field_wrap();
    test_frame_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
